// File: rtl/ace_fetch_pkg.sv
// Shared types and sizing for the instruction fetch front end.
package ace_fetch_pkg;

    localparam int unsigned FETCH_SLOTS = 8;
    localparam int unsigned LINE_BYTES  = 32;
    localparam int unsigned LINE_W      = 256;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DELIVER,
        DRAIN
    } fetch_state_e;

endpackage

// File: rtl/ace_fetch_slot_mask.sv
// Word offset within a line -> per-slot valid mask; slots below the offset are cleared.
module fetch_slot_mask
    import ace_fetch_pkg::*;
(
    input  logic [2:0]             offset_i,
    output logic [FETCH_SLOTS-1:0] mask_o
);

    // Slot k is valid when it sits at or above the entry offset.
    always_comb begin
        mask_o = '0;
        for (int unsigned k = 0; k < FETCH_SLOTS; k++) begin
            mask_o[k] = (k >= 32'(offset_i));
        end
    end

endmodule

// File: rtl/ace_fetch.sv
// Instruction fetch front end: one outstanding I-cache line request, line capture,
// and 8-slot delivery into the decode buffer with redirect/flush handling.
module ace_fetch
    import ace_fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    input  logic              instbuf_full_i,
    output logic              icache_req_o,
    output logic [PC_W-1:0]   icache_req_addr_o,
    input  logic              icache_req_rdy_i,
    input  logic              icache_rsp_vld_i,
    input  logic [LINE_W-1:0] icache_rsp_data_i,
    output logic [31:0]       inst0_o,
    output logic [31:0]       inst1_o,
    output logic [31:0]       inst2_o,
    output logic [31:0]       inst3_o,
    output logic [31:0]       inst4_o,
    output logic [31:0]       inst5_o,
    output logic [31:0]       inst6_o,
    output logic [31:0]       inst7_o,
    output logic              inst0_vld_o,
    output logic              inst1_vld_o,
    output logic              inst2_vld_o,
    output logic              inst3_vld_o,
    output logic              inst4_vld_o,
    output logic              inst5_vld_o,
    output logic              inst6_vld_o,
    output logic              inst7_vld_o,
    output logic [PC_W-1:0]   fetch_pc_o
);

    fetch_state_e          state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic                  deliver_en;
    logic                  req_accept;
    logic [PC_W-1:0]       line_addr;
    logic [PC_W-1:0]       next_line_addr;
    logic [PC_W-1:0]       redirect_pc;
    logic [FETCH_SLOTS-1:0] slot_mask;
    logic [FETCH_SLOTS-1:0] slot_vld;

    assign line_addr      = pc_q & ~PC_W'(LINE_BYTES - 1);
    assign next_line_addr = line_addr + PC_W'(LINE_BYTES);
    assign redirect_pc    = redirect_pc_i & {{(PC_W-2){1'b1}}, 2'b00};

    assign icache_req_o      = (state_q == REQ);
    assign icache_req_addr_o = line_addr;
    assign req_accept        = icache_req_o & icache_req_rdy_i;
    assign fetch_pc_o        = pc_q;

    fetch_slot_mask u_slot_mask (
        .offset_i (pc_q[4:2]),
        .mask_o   (slot_mask)
    );

    assign slot_vld = deliver_en ? slot_mask : '0;

    assign inst0_vld_o = slot_vld[0];
    assign inst1_vld_o = slot_vld[1];
    assign inst2_vld_o = slot_vld[2];
    assign inst3_vld_o = slot_vld[3];
    assign inst4_vld_o = slot_vld[4];
    assign inst5_vld_o = slot_vld[5];
    assign inst6_vld_o = slot_vld[6];
    assign inst7_vld_o = slot_vld[7];

    assign inst0_o = line_q[0*32 +: 32];
    assign inst1_o = line_q[1*32 +: 32];
    assign inst2_o = line_q[2*32 +: 32];
    assign inst3_o = line_q[3*32 +: 32];
    assign inst4_o = line_q[4*32 +: 32];
    assign inst5_o = line_q[5*32 +: 32];
    assign inst6_o = line_q[6*32 +: 32];
    assign inst7_o = line_q[7*32 +: 32];

    // Next-state, PC and line-buffer update; redirect overrides every normal transition.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        line_d     = line_q;
        deliver_en = 1'b0;

        if (redirect_i) begin
            pc_d = redirect_pc;
            unique case (state_q)
                IDLE, DELIVER: state_d = IDLE;
                REQ:           state_d = req_accept       ? DRAIN : IDLE;
                WAIT:          state_d = icache_rsp_vld_i ? IDLE  : DRAIN;
                // An orphan arriving together with a fresh redirect still settles the
                // single outstanding request, so leave DRAIN rather than wait forever.
                DRAIN:         state_d = icache_rsp_vld_i ? IDLE  : DRAIN;
                default:       state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (req_accept) state_d = WAIT;
                end
                WAIT: begin
                    if (icache_rsp_vld_i) begin
                        line_d  = icache_rsp_data_i;
                        state_d = DELIVER;
                    end
                end
                DELIVER: begin
                    if (!instbuf_full_i) begin
                        deliver_en = 1'b1;
                        pc_d       = next_line_addr;
                        state_d    = REQ;
                    end
                end
                DRAIN: begin
                    if (icache_rsp_vld_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, fetch PC and line buffer registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: tb/tb_ace_fetch.sv
// Self-checking bench for ace_fetch: directed scenarios plus a randomized run against
// a transaction-level model of fetch PC, outstanding request and pending line.
module tb_ace_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         full;
    logic         rdy;
    logic         rsp_vld;
    logic [255:0] rsp_data;
    logic         req;
    logic [31:0]  req_addr;
    logic [31:0]  inst0, inst1, inst2, inst3, inst4, inst5, inst6, inst7;
    logic         vld0, vld1, vld2, vld3, vld4, vld5, vld6, vld7;
    logic [31:0]  fetch_pc;

    always #5 clk = ~clk;

    ace_fetch #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clock             (clk),
        .reset             (rst),
        .redirect_i        (redirect),
        .redirect_pc_i     (redirect_pc),
        .instbuf_full_i    (full),
        .icache_req_o      (req),
        .icache_req_addr_o (req_addr),
        .icache_req_rdy_i  (rdy),
        .icache_rsp_vld_i  (rsp_vld),
        .icache_rsp_data_i (rsp_data),
        .inst0_o (inst0), .inst1_o (inst1), .inst2_o (inst2), .inst3_o (inst3),
        .inst4_o (inst4), .inst5_o (inst5), .inst6_o (inst6), .inst7_o (inst7),
        .inst0_vld_o (vld0), .inst1_vld_o (vld1), .inst2_vld_o (vld2), .inst3_vld_o (vld3),
        .inst4_vld_o (vld4), .inst5_vld_o (vld5), .inst6_vld_o (vld6), .inst7_vld_o (vld7),
        .fetch_pc_o        (fetch_pc)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // I-cache emulator knobs and state
    bit          k_rdy, k_full, k_fixed;
    int unsigned k_lat, k_unsol_pct;
    bit          pend;
    int unsigned pend_cnt;
    logic [255:0] pend_data;

    // Per-cycle samples
    bit           s_req, s_acc, s_rsp, s_redir, s_full;
    logic [31:0]  s_addr, s_pc, s_rpc;
    logic [7:0]   s_vld;
    logic [255:0] s_line, s_rsp_data;

    function automatic logic [255:0] fixed_line();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = 32'h100 + k;
        return r;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // One clock: drive inputs, act as the I-cache, sample outputs at the falling edge.
    task automatic run_cycle(input bit redir, input logic [31:0] rpc);
        redirect    = redir;
        redirect_pc = rpc;
        full        = k_full;
        rdy         = k_rdy;
        rsp_vld     = 1'b0;
        if (pend) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                rsp_vld  = 1'b1;
                rsp_data = pend_data;
                pend     = 1'b0;
            end
        end else if (k_unsol_pct != 0 && $urandom_range(99) < k_unsol_pct) begin
            rsp_vld  = 1'b1;
            rsp_data = rand_line();
        end
        @(negedge clk);
        s_req      = (req === 1'b1);
        s_addr     = req_addr;
        s_vld      = {vld7, vld6, vld5, vld4, vld3, vld2, vld1, vld0};
        s_line     = {inst7, inst6, inst5, inst4, inst3, inst2, inst1, inst0};
        s_pc       = fetch_pc;
        s_acc      = s_req && rdy;
        s_rsp      = rsp_vld;
        s_rsp_data = rsp_data;
        s_redir    = redir;
        s_rpc      = rpc;
        s_full     = k_full;
        if (s_acc && !rst) begin
            pend      = 1'b1;
            pend_cnt  = k_lat;
            pend_data = k_fixed ? fixed_line() : rand_line();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        k_rdy = 1'b1; k_full = 1'b0; k_fixed = 1'b1; k_lat = 1; k_unsol_pct = 0;
        pend = 1'b0;
        rst = 1'b1;
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b0, 32'h0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        run_cycle(1'b0, 32'h0);   // IDLE
        run_cycle(1'b0, 32'h0);   // REQ, accepted
        run_cycle(1'b0, 32'h0);   // WAIT, line captured
        k_full = 1'b1;
        run_cycle(1'b0, 32'h0);   // DELIVER held, line buffer loaded
        rst = 1'b1;
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", s_req); end
        vectors++; if (s_vld !== 8'h00) begin miscompares++; $display("FAIL reset_vld: got %h expected 00", s_vld); end
        vectors++; if (s_line !== '0) begin miscompares++; $display("FAIL reset_line: got %h expected 0", s_line); end
        vectors++; if (s_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected 0", s_pc); end
        rst = 1'b0;
        k_full = 1'b0;
    endtask

    task automatic test_first_line();
        do_reset();
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_req !== 1'b0) begin miscompares++; $display("FAIL idle_no_req: got %b expected 0", s_req); end
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin miscompares++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0", s_req, s_addr); end
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_vld !== 8'h00 || s_req !== 1'b0) begin miscompares++; $display("FAIL wait_quiet: got vld=%h req=%b expected 00/0", s_vld, s_req); end
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_vld !== 8'hFF) begin miscompares++; $display("FAIL first_vld: got %h expected ff", s_vld); end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (s_line[32*k +: 32] !== 32'h100 + k) begin
                miscompares++; $display("FAIL first_inst%0d: got %h expected %h", k, s_line[32*k +: 32], 32'h100 + k);
            end
        end
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_req !== 1'b1 || s_addr !== 32'h20 || s_vld !== 8'h00) begin miscompares++; $display("FAIL second_req: got req=%b addr=%h vld=%h expected 1/00000020/00", s_req, s_addr, s_vld); end
        vectors++; if (s_pc !== 32'h20) begin miscompares++; $display("FAIL second_pc: got %h expected 00000020", s_pc); end
    endtask

    task automatic test_redirect_offset();
        do_reset();
        run_cycle(1'b1, 32'h0000_001E);
        vectors++; if (s_vld !== 8'h00) begin miscompares++; $display("FAIL redir_idle_vld: got %h expected 00", s_vld); end
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_pc !== 32'h1C || s_req !== 1'b0) begin miscompares++; $display("FAIL redir_pc: got pc=%h req=%b expected 0000001c/0", s_pc, s_req); end
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin miscompares++; $display("FAIL offset_req: got req=%b addr=%h expected 1/0", s_req, s_addr); end
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_vld !== 8'h80 || s_line[255:224] !== 32'h107) begin miscompares++; $display("FAIL offset_vld: got vld=%h inst7=%h expected 80/107", s_vld, s_line[255:224]); end
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_req !== 1'b1 || s_addr !== 32'h20) begin miscompares++; $display("FAIL offset_next: got req=%b addr=%h expected 1/20", s_req, s_addr); end
    endtask

    task automatic test_backpressure();
        do_reset();
        k_full = 1'b1;
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            run_cycle(1'b0, 32'h0);
            vectors++;
            if (s_vld !== 8'h00 || s_req !== 1'b0 || s_line !== fixed_line() || s_pc !== 32'h0) begin
                miscompares++; $display("FAIL hold_cycle%0d: got vld=%h req=%b pc=%h inst0=%h expected 00/0/0/100", c, s_vld, s_req, s_pc, s_line[31:0]);
            end
        end
        k_full = 1'b0;
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_vld !== 8'hFF) begin miscompares++; $display("FAIL release_vld: got %h expected ff", s_vld); end
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_req !== 1'b1 || s_addr !== 32'h20) begin miscompares++; $display("FAIL release_req: got req=%b addr=%h expected 1/20", s_req, s_addr); end
    endtask

    task automatic test_rdy_stall();
        do_reset();
        k_rdy = 1'b0;
        run_cycle(1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            run_cycle(1'b0, 32'h0);
            vectors++;
            if (s_req !== 1'b1 || s_addr !== 32'h0) begin
                miscompares++; $display("FAIL stall_cycle%0d: got req=%b addr=%h expected 1/0", c, s_req, s_addr);
            end
        end
        k_rdy = 1'b1;
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_acc !== 1'b1 || s_addr !== 32'h0) begin miscompares++; $display("FAIL stall_accept: got acc=%b addr=%h expected 1/0", s_acc, s_addr); end
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_vld !== 8'hFF) begin miscompares++; $display("FAIL stall_deliver: got %h expected ff", s_vld); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        k_lat = 4;
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b0, 32'h0);           // accepted, response 4 cycles out
        run_cycle(1'b1, 32'h0000_0040);   // redirect in WAIT
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (s_vld !== 8'h00 || s_req !== 1'b0) begin
                miscompares++; $display("FAIL drain_cycle%0d: got vld=%h req=%b expected 00/0", c, s_vld, s_req);
            end
            run_cycle(1'b0, 32'h0);
        end
        vectors++; if (s_req !== 1'b0 || s_vld !== 8'h00) begin miscompares++; $display("FAIL drain_idle: got req=%b vld=%h expected 0/00", s_req, s_vld); end
        k_lat = 1;
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_req !== 1'b1 || s_addr !== 32'h40) begin miscompares++; $display("FAIL drain_req: got req=%b addr=%h expected 1/40", s_req, s_addr); end
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_vld !== 8'hFF) begin miscompares++; $display("FAIL drain_deliver: got %h expected ff", s_vld); end
    endtask

    task automatic test_redirect_accept();
        do_reset();
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b1, 32'h0000_0080);   // redirect with accept
        vectors++; if (s_acc !== 1'b1 || s_vld !== 8'h00) begin miscompares++; $display("FAIL racc_accept: got acc=%b vld=%h expected 1/00", s_acc, s_vld); end
        run_cycle(1'b0, 32'h0);           // orphan response
        vectors++; if (s_req !== 1'b0 || s_vld !== 8'h00 || s_rsp !== 1'b1) begin miscompares++; $display("FAIL racc_drain: got req=%b vld=%h rsp=%b expected 0/00/1", s_req, s_vld, s_rsp); end
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_req !== 1'b0 || s_vld !== 8'h00) begin miscompares++; $display("FAIL racc_idle: got req=%b vld=%h expected 0/00", s_req, s_vld); end
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_req !== 1'b1 || s_addr !== 32'h80) begin miscompares++; $display("FAIL racc_req: got req=%b addr=%h expected 1/80", s_req, s_addr); end

        do_reset();
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b1, 32'h0000_0080);   // redirect coincident with response
        vectors++; if (s_rsp !== 1'b1 || s_vld !== 8'h00) begin miscompares++; $display("FAIL rrsp_discard: got rsp=%b vld=%h expected 1/00", s_rsp, s_vld); end
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_req !== 1'b0 || s_vld !== 8'h00) begin miscompares++; $display("FAIL rrsp_idle: got req=%b vld=%h expected 0/00", s_req, s_vld); end
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_req !== 1'b1 || s_addr !== 32'h80) begin miscompares++; $display("FAIL rrsp_req: got req=%b addr=%h expected 1/80", s_req, s_addr); end
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_vld !== 8'hFF) begin miscompares++; $display("FAIL rrsp_deliver: got %h expected ff", s_vld); end
    endtask

    task automatic test_wrap();
        do_reset();
        run_cycle(1'b1, 32'hFFFF_FFE4);
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFE0) begin miscompares++; $display("FAIL wrap_req: got req=%b addr=%h expected 1/ffffffe0", s_req, s_addr); end
        run_cycle(1'b0, 32'h0);
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_vld !== 8'hFE) begin miscompares++; $display("FAIL wrap_vld: got %h expected fe", s_vld); end
        run_cycle(1'b0, 32'h0);
        vectors++; if (s_req !== 1'b1 || s_addr !== 32'h0 || s_pc !== 32'h0) begin miscompares++; $display("FAIL wrap_next: got req=%b addr=%h pc=%h expected 1/0/0", s_req, s_addr, s_pc); end
    endtask

    task automatic test_random();
        logic [31:0]  exp_pc;
        bit           outstanding, stale, ready, prev_hold;
        logic [255:0] ready_line;
        logic [7:0]   exp_vld;
        int unsigned  idle_run;
        bit           redir;
        logic [31:0]  rpc;

        do_reset();
        k_fixed = 1'b0;
        k_unsol_pct = 3;
        exp_pc = 32'h0; outstanding = 0; stale = 0; ready = 0; prev_hold = 0; idle_run = 0;
        ready_line = '0;
        for (int n = 0; n < 400; n++) begin
            k_rdy  = ($urandom_range(3) != 0);
            k_full = ($urandom_range(9) < 3);
            k_lat  = $urandom_range(4, 1);
            redir  = ($urandom_range(39) == 0);
            rpc    = $urandom;
            run_cycle(redir, rpc);

            vectors++; if (s_pc !== exp_pc) begin miscompares++; $display("FAIL rnd_pc cyc%0d: got %h expected %h", n, s_pc, exp_pc); end

            if (s_req) begin
                vectors++;
                if (outstanding || ready || s_addr !== {exp_pc[31:5], 5'b0}) begin
                    miscompares++; $display("FAIL rnd_req cyc%0d: got addr=%h outstanding=%b pending_line=%b expected addr=%h with nothing in flight", n, s_addr, outstanding, ready, {exp_pc[31:5], 5'b0});
                end
            end
            if (prev_hold) begin
                vectors++; if (!s_req) begin miscompares++; $display("FAIL rnd_req_drop cyc%0d: got req=0 expected 1", n); end
            end
            prev_hold = s_req && !s_acc && !s_redir;

            if (s_redir) idle_run = 0;
            else if (!outstanding && !ready && !s_req) idle_run++;
            else idle_run = 0;
            vectors++; if (idle_run > 1) begin miscompares++; $display("FAIL rnd_idle cyc%0d: got %0d idle cycles expected at most 1", n, idle_run); end

            exp_vld = (ready && !s_full && !s_redir) ? (8'hFF << exp_pc[4:2]) : 8'h00;
            vectors++; if (s_vld !== exp_vld) begin miscompares++; $display("FAIL rnd_vld cyc%0d: got %h expected %h", n, s_vld, exp_vld); end
            if (ready) begin
                vectors++; if (s_line !== ready_line) begin miscompares++; $display("FAIL rnd_line cyc%0d: got %h expected %h", n, s_line, ready_line); end
            end
            if (exp_vld != 8'h00) begin
                exp_pc = {exp_pc[31:5], 5'b0} + 32'd32;
                ready  = 0;
            end

            if (s_rsp && outstanding) begin
                if (!stale && !s_redir) begin
                    ready      = 1;
                    ready_line = s_rsp_data;
                end
                outstanding = 0;
            end
            if (s_acc) begin
                outstanding = 1;
                stale       = 0;
            end
            if (s_redir) begin
                exp_pc = {s_rpc[31:2], 2'b00};
                ready  = 0;
                if (outstanding) stale = 1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; full = 1'b0; rdy = 1'b1;
        rsp_vld = 1'b0; rsp_data = '0;
        k_rdy = 1'b1; k_full = 1'b0; k_fixed = 1'b1; k_lat = 1; k_unsol_pct = 0;
        pend = 1'b0; pend_cnt = 0; pend_data = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_first_line();
        test_redirect_offset();
        test_backpressure();
        test_rdy_stall();
        test_redirect_wait();
        test_redirect_accept();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
